tape_player_ctrl: RTL and testbench

Sequencer for cassette playback from the tape image RAM. It tracks motor on/off from port $FF writes and arms playback. It then walks the loaded .CAS image bit by bit, MSB first, and produces the sync/data pulse train on the port $FF input latch with CPU-cycle-accurate timing. It sits between the CPU I/O decode, the 128 KB tape RAM read port and the port $FF read mux. Audio mixing is outside this block.

---
 rtl/tape_player_ctrl_if.sv | 34 +++
 rtl/tape_player_ctrl.sv | 151 +++++++++++++++
 tb/tb_tape_player_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/tape_player_ctrl_if.sv
// Tape player bus bundle: CPU port $FF access, tape RAM read port, status.
// master drives the CPU/RAM side; slave is the controller.
interface tape_player_ctrl_if #(
  parameter int AW = 17
);
  logic          ce;
  logic          load;
  logic          play;
  logic [AW-1:0] img_len;
  logic          pff_wr;
  logic          pff_rd;
  logic [2:0]    pff_d;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_q;
  logic          latch;
  logic          bit_val;
  logic          motor;
  logic          done;
  logic [7:0]    audio_mon;

  modport master (
    output ce, load, play, img_len,
    output pff_wr, pff_rd, pff_d, ram_q,
    input  ram_a, latch, bit_val,
    input  motor, done, audio_mon
  );

  modport slave (
    input  ce, load, play, img_len,
    input  pff_wr, pff_rd, pff_d, ram_q,
    output ram_a, latch, bit_val,
    output motor, done, audio_mon
  );
endinterface

// File: rtl/tape_player_ctrl.sv
// Cassette playback sequencer: walks the .CAS image MSB first into the
// port $FF latch. Define TAPE_MONITOR_EN to enable the audio monitor tone.
module tape_player_ctrl #(
  parameter int AW       = 17,
  parameter int CYC_SYNC = 512,
  parameter int CYC_DATA = 1791,
  parameter int CYC_HOLD = 512,
  parameter int CYC_BIT  = 3584
) (
  input  logic               clock,
  input  logic               reset,
  tape_player_ctrl_if.slave  bus
);

  localparam int CW = $clog2(CYC_BIT);
  localparam logic [CW-1:0] C_SYNC = CW'(CYC_SYNC);
  localparam logic [CW-1:0] C_DATA = CW'(CYC_DATA);
  localparam logic [CW-1:0] C_HEND = CW'(CYC_DATA + CYC_HOLD);
  localparam logic [CW-1:0] C_LAST = CW'(CYC_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_ram_a;
  logic [2:0]    r_ptr;
  logic [CW-1:0] r_cyc;
  logic          r_latch;
  logic          r_bit;
  logic          r_motor;
  logic          r_done;
  logic          r_play_q;
  logic          r_end;

  logic          w_off;
  logic          w_arm;
  logic          w_play;
  logic          w_empty;
  logic          w_lset;
  logic [AW-1:0] w_ram_inc;

  assign w_off   = bus.pff_wr & ~bus.pff_d[2];
  assign w_arm   = bus.pff_wr & bus.pff_d[2] & ~r_motor;
  assign w_play  = bus.play & ~r_play_q;
  assign w_empty = (bus.img_len == '0);

  // Sync pulse at the start of every cell, data pulse only for '1' bits
  assign w_lset = (r_state == S_RUN) &&
                  ((r_cyc < C_SYNC) ||
                   ((r_cyc > C_DATA) && (r_cyc <= C_HEND) && r_bit));

  assign w_ram_inc = (r_ram_a == bus.img_len) ? r_ram_a
                                              : r_ram_a + AW'(1);

  always_ff @(posedge clock) begin
    if (!reset || bus.load) begin
      r_state  <= S_IDLE;
      r_ram_a  <= '0;
      r_ptr    <= 3'd7;
      r_cyc    <= '0;
      r_latch  <= 1'b0;
      r_bit    <= 1'b0;
      r_motor  <= 1'b0;
      r_done   <= 1'b0;
      r_play_q <= 1'b0;
      r_end    <= 1'b0;
    end else if (bus.ce) begin
      r_play_q <= bus.play;
      if (bus.pff_wr) r_motor <= bus.pff_d[2];
      if (w_lset)
        r_latch <= 1'b1;
      else if (bus.pff_wr)
        r_latch <= 1'b0;

      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_off) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end else if (r_state == S_IDLE && w_arm) begin
            r_ram_a <= '0;
            r_ptr   <= 3'd7;
            r_state <= w_empty ? S_DONE : S_ARMED;
            r_done  <= w_empty;
          end else if (w_play) begin
            r_ram_a <= '0;
            r_ptr   <= 3'd7;
            r_cyc   <= '0;
            r_end   <= 1'b0;
            r_state <= w_empty ? S_DONE : S_RUN;
            r_done  <= w_empty;
          end
        end
        S_ARMED: begin
          if (w_off) begin
            r_state <= S_IDLE;
          end else if (bus.pff_rd) begin
            r_cyc   <= '0;
            r_end   <= 1'b0;
            r_state <= w_empty ? S_DONE : S_RUN;
            r_done  <= w_empty;
          end
        end
        S_RUN: begin
          if (w_off) begin
            r_state <= S_IDLE;
          end else begin
            if (r_cyc == C_DATA) begin
              r_bit <= bus.ram_q[r_ptr];
              if (r_ptr == 3'd0) begin
                r_ptr   <= 3'd7;
                r_ram_a <= w_ram_inc;
                if (w_ram_inc == bus.img_len) r_end <= 1'b1;
              end else begin
                r_ptr <= r_ptr - 3'd1;
              end
            end
            // Image end takes effect only at the cell boundary
            if (r_cyc == C_LAST) begin
              r_cyc <= '0;
              if (r_end) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end else begin
              r_cyc <= r_cyc + CW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ram_a   = r_ram_a;
  assign bus.latch   = r_latch;
  assign bus.bit_val = r_bit;
  assign bus.motor   = r_motor;
  assign bus.done    = r_done;

`ifdef TAPE_MONITOR_EN
  assign bus.audio_mon = (r_latch && r_state == S_RUN) ? 8'h40 : 8'h00;
`else
  assign bus.audio_mon = 8'h00;
`endif

endmodule

// File: tb/tb_tape_player_ctrl.sv
// Bench for tape_player_ctrl: scaled cell timing, random images and CPU
// traffic, compared every CPU cycle against a cell/bit arithmetic model.
module tb_tape_player_ctrl;

  localparam int CS = 8;
  localparam int CD = 27;
  localparam int CH = 8;
  localparam int CB = 56;

  logic clk;
  logic rst_n;

  tape_player_ctrl_if #(.AW(17)) bus ();

  tape_player_ctrl #(
    .AW(17), .CYC_SYNC(CS), .CYC_DATA(CD),
    .CYC_HOLD(CH), .CYC_BIT(CB)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:7];
  always @(posedge clk) bus.ram_q <= mem[bus.ram_a[2:0]];

  int   nchk;
  int   nerr;
  logic m_latch;
  logic m_bit;
  logic m_motor;

  function automatic logic imgbit(input int b);
    logic [7:0] by;
    by = mem[b / 8];
    return by[7 - (b % 8)];
  endfunction

  task automatic check(input string tag, input logic el, input logic eb,
                       input logic em, input logic ed,
                       input logic [16:0] ea, input logic run);
    logic [7:0] eau;
`ifdef TAPE_MONITOR_EN
    eau = (el && run) ? 8'h40 : 8'h00;
`else
    eau = 8'h00;
`endif
    nchk++;
    assert (bus.latch === el) else begin
      nerr++;
      $error("FAIL %s latch got %b exp %b", tag, bus.latch, el);
    end
    nchk++;
    assert (bus.bit_val === eb) else begin
      nerr++;
      $error("FAIL %s bit_val got %b exp %b", tag, bus.bit_val, eb);
    end
    nchk++;
    assert (bus.motor === em) else begin
      nerr++;
      $error("FAIL %s motor got %b exp %b", tag, bus.motor, em);
    end
    nchk++;
    assert (bus.done === ed) else begin
      nerr++;
      $error("FAIL %s done got %b exp %b", tag, bus.done, ed);
    end
    nchk++;
    assert (bus.ram_a === ea) else begin
      nerr++;
      $error("FAIL %s ram_a got %0d exp %0d", tag, bus.ram_a, ea);
    end
    nchk++;
    assert (bus.audio_mon === eau) else begin
      nerr++;
      $error("FAIL %s audio_mon got %h exp %h", tag, bus.audio_mon, eau);
    end
  endtask

  // One CPU cycle: ce high for one clock, then three idle clocks
  task automatic step(input logic wr, input logic rd, input logic [2:0] d);
    bus.pff_wr = wr;
    bus.pff_rd = rd;
    bus.pff_d  = d;
    bus.ce     = 1'b1;
    @(posedge clk);
    #1;
    bus.ce     = 1'b0;
    bus.pff_wr = 1'b0;
    bus.pff_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Step outside playback: only writes affect latch and motor
  task automatic istep(input logic wr, input logic rd, input logic [2:0] d);
    step(wr, rd, d);
    if (wr) begin
      m_latch = 1'b0;
      m_motor = d[2];
    end
  endtask

  task automatic play_step();
    bus.play = 1'b1;
    istep(1'b0, 1'b0, 3'b000);
    bus.play = 1'b0;
  endtask

  // Playback from the cycle after RUN entry; k counts CPU cycles
  task automatic run_image(input string tag, input int len,
                           input bit rnd, input int stop_k);
    int   total;
    int   cyc;
    int   b;
    int   ns;
    logic wr;
    logic rd;
    logic set;
    logic dn;
    logic [2:0] d;
    total = len * 8 * CB;
    for (int k = 0; k < total; k++) begin
      cyc = k % CB;
      b   = k / CB;
      d   = 3'b100;
      if (rnd) begin
        wr = ($urandom_range(7) == 0);
        rd = ($urandom_range(7) == 0);
        d  = {1'b1, 2'($urandom_range(3))};
      end else begin
        wr = (cyc == 3) || (cyc == CS + 2) || (cyc == CD + CH + 2);
        rd = (cyc == CS - 1);
      end
      if (k == stop_k) begin
        wr = 1'b1;
        rd = 1'b0;
        d  = 3'b000;
      end
      step(wr, rd, d);
      set = (cyc < CS) || (cyc > CD && cyc <= CD + CH && imgbit(b));
      if (set) m_latch = 1'b1;
      else if (wr) m_latch = 1'b0;
      if (wr) m_motor = d[2];
      if (cyc == CD) m_bit = imgbit(b);
      ns = b + ((cyc >= CD) ? 1 : 0);
      if (k == stop_k) begin
        check({tag, "_stop"}, m_latch, m_bit, m_motor, 1'b0,
              17'(ns / 8), 1'b0);
        return;
      end
      dn = (k == total - 1);
      check(tag, m_latch, m_bit, m_motor, dn, 17'(ns / 8), !dn);
    end
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    m_latch = 1'b0;
    m_bit   = 1'b0;
    m_motor = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    bus.ce      = 1'b0;
    bus.load    = 1'b0;
    bus.play    = 1'b0;
    bus.img_len = '0;
    bus.pff_wr  = 1'b0;
    bus.pff_rd  = 1'b0;
    bus.pff_d   = 3'b000;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset", 1'b0, 1'b0, 1'b0, 1'b0, 17'd0, 1'b0);

    // Arm with motor-on write, start with a port read, single byte A5
    mem[0] = 8'hA5;
    bus.img_len = 17'd1;
    istep(1'b1, 1'b0, 3'b100);
    check("arm", m_latch, m_bit, m_motor, 1'b0, 17'd0, 1'b0);
    istep(1'b0, 1'b1, 3'b000);
    check("enter", m_latch, m_bit, m_motor, 1'b0, 17'd0, 1'b1);
    run_image("a5", 1, 1'b0, -1);
    istep(1'b0, 1'b1, 3'b000);
    check("done_hold", m_latch, m_bit, m_motor, 1'b1, 17'd1, 1'b0);

    // Motor off leaves DONE; play path with random image and traffic
    istep(1'b1, 1'b0, 3'b000);
    check("off", m_latch, m_bit, m_motor, 1'b0, 17'd1, 1'b0);
    for (int i = 0; i < 3; i++) mem[i] = 8'($urandom);
    bus.img_len = 17'd3;
    play_step();
    check("play", m_latch, m_bit, m_motor, 1'b0, 17'd0, 1'b1);
    run_image("rnd", 3, 1'b1, -1);
    istep(1'b1, 1'b0, 3'b000);

    // Motor off at byte 2, pointer 4
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    bus.img_len = 17'd4;
    play_step();
    run_image("moff", 4, 1'b0, (2 * 8 + 3) * CB + CS + 5);
    for (int i = 0; i < 2 * CB; i++) begin
      istep(1'b0, 1'b0, 3'b000);
      check("idle", m_latch, m_bit, m_motor, 1'b0, 17'd2, 1'b0);
    end

    // Download abort mid-RUN
    bus.img_len = 17'd2;
    play_step();
    repeat (CS + 3) istep(1'b0, 1'b0, 3'b000);
    bus.load = 1'b1;
    @(posedge clk);
    #1;
    m_latch = 1'b0;
    m_bit   = 1'b0;
    m_motor = 1'b0;
    check("load", 1'b0, 1'b0, 1'b0, 1'b0, 17'd0, 1'b0);
    bus.load = 1'b0;
    @(posedge clk);
    #1;

    // Empty image goes straight to DONE without pulses
    bus.img_len = 17'd0;
    play_step();
    check("empty", 1'b0, 1'b0, 1'b0, 1'b1, 17'd0, 1'b0);
    istep(1'b0, 1'b0, 3'b000);
    check("empty2", 1'b0, 1'b0, 1'b0, 1'b1, 17'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
